// File: rtl/chan_delay_pkg.sv
// Shared defaults, FSM state encoding and parity helper for chan_delay_buf.
package chan_delay_pkg;

  localparam int unsigned NCH_DEF  = 32;
  localparam int unsigned CW_DEF   = 5;
  localparam int unsigned PAR_MAXW = 64;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    FILL      = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Even parity bit: XOR of all data bits (callers zero-extend).
  function automatic logic even_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/chan_slot_ctr.sv
// Write-slot pointer for chan_delay_buf: wraps at NCH-1, forced to slot 0 on
// frame_sync, flags frame_sync arriving while the pointer is not at slot 0.
module chan_slot_ctr
  import chan_delay_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          frame_sync,
  output logic [CW-1:0] k,
  output logic          last_slot,
  output logic          misalign
);

  logic [CW-1:0] wr_ch;

  assign k         = frame_sync ? '0 : wr_ch;
  assign last_slot = (k == CW'(NCH - 1));
  assign misalign  = frame_sync && (wr_ch != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ch <= '0;
    end else if (advance) begin
      wr_ch <= last_slot ? '0 : k + CW'(1);
    end
  end

endmodule

// File: rtl/chan_delay_buf.sv
// Per-channel one-frame delay buffer for the TDM datapath.
// Optional stored-parity checking with par_err: define CHAN_DELAY_PARITY_EN.
module chan_delay_buf
  import chan_delay_pkg::*;
#(
  parameter int unsigned     SIZE   = 16,
  parameter logic [SIZE-1:0] RSTVAL = '0,
  parameter int unsigned     NCH    = NCH_DEF,
  parameter int unsigned     CW     = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  input  logic            scan_enable,
  input  logic            test_mode,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4,
  input  logic            frame_sync,
  input  logic            in_valid,
  input  logic [SIZE-1:0] X,
  output logic            out_valid,
  output logic [SIZE-1:0] Y,
  output logic [CW-1:0]   ch_out,
  output logic            first_frame,
`ifdef CHAN_DELAY_PARITY_EN
  output logic            par_err,
`endif
  output logic            sync_err
);

`ifdef CHAN_DELAY_PARITY_EN
  localparam int unsigned W = SIZE + 1;
  localparam logic [W-1:0] RST_ENTRY = {even_par(PAR_MAXW'(RSTVAL)), RSTVAL};
`else
  localparam int unsigned W = SIZE;
  localparam logic [W-1:0] RST_ENTRY = RSTVAL;
`endif

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

  state_t        state, next_state;
  logic [W-1:0]  mem [NCH];
  logic [W-1:0]  rd, wr_entry;
  logic [CW-1:0] k;
  logic          last_slot, misalign;
  logic          accept, resync;

  chan_slot_ctr #(
    .NCH (NCH),
    .CW  (CW)
  ) u_slot_ctr (
    .clk        (clk),
    .rst        (reset),
    .advance    (accept),
    .frame_sync (frame_sync),
    .k          (k),
    .last_slot  (last_slot),
    .misalign   (misalign)
  );

  assign rd = mem[k];
`ifdef CHAN_DELAY_PARITY_EN
  assign wr_entry = {even_par(PAR_MAXW'(X)), X};
`else
  assign wr_entry = X;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC_WAIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    resync     = 1'b0;
    case (state)
      SYNC_WAIT: begin
        accept = in_valid && frame_sync;
        if (accept) next_state = last_slot ? RUN : FILL;
      end
      FILL, RUN: begin
        accept = in_valid;
        resync = in_valid && misalign;
        if (resync)                   next_state = FILL;
        else if (accept && last_slot) next_state = RUN;
      end
      default: next_state = SYNC_WAIT;
    endcase
  end

  // first_frame trails the state by one cycle so the last FILL output still
  // carries it; a resync raises it together with the channel-0 output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) mem[i] <= RST_ENTRY;
      Y           <= RSTVAL;
      ch_out      <= '0;
      out_valid   <= 1'b0;
      first_frame <= 1'b1;
      sync_err    <= 1'b0;
`ifdef CHAN_DELAY_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      out_valid   <= accept;
      sync_err    <= resync;
      first_frame <= resync || (state != RUN);
      if (accept) begin
        mem[k] <= wr_entry;
        Y      <= rd[SIZE-1:0];
        ch_out <= k;
`ifdef CHAN_DELAY_PARITY_EN
        par_err <= (even_par(PAR_MAXW'(rd[SIZE-1:0])) != rd[SIZE]) &&
                   !(state == FILL && first_frame);
`endif
      end
    end
  end

endmodule

// File: doc/chan_delay_buf.md
Name: chan_delay_buf

Overview:
- Per-channel, one-frame delay buffer for the 32-channel TDM datapath.
- Stores one SIZE-bit sample per channel slot.
- When a channel's new sample arrives, the block returns the value that same channel stored one frame earlier.
- Sits at the read/retrieve end of the per-channel state path. Unlike a free-running shift chain, it advances only on qualified input and realigns on frame sync.

Parameters:
- SIZE, 16, sample width in bits
- RSTVAL, 0, reset value of every storage entry and of Y
- NCH, 32, channels per frame
- CW, 5, channel index width, clog2(NCH)

Ports:
- clk  in  1  system clock
- reset  in  1  system reset, asynchronous, active-high
- scan_in0..scan_in4  in  1 each  test scan data inputs
- scan_enable  in  1  test scan enable
- test_mode  in  1  test mode
- scan_out0..scan_out4  out  1 each  test scan data outputs, driven 0 pre-DFT
- frame_sync  in  1  marks the channel-0 sample; qualified by in_valid
- in_valid  in  1  X carries a sample this cycle
- X  in  SIZE  sample input
- out_valid  out  1  Y/ch_out valid this cycle
- Y  out  SIZE  delayed sample (previous frame, same channel)
- ch_out  out  CW  channel index of Y
- first_frame  out  1  high while Y comes from never-written (RSTVAL) entries
- sync_err  out  1  one-cycle pulse on misaligned frame_sync

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - Y=RSTVAL, ch_out=0, out_valid=0, first_frame=1, sync_err=0.
  - All NCH entries = RSTVAL; write pointer wr_ch=0; state SYNC_WAIT.
- States:
  - SYNC_WAIT: in_valid without frame_sync is ignored, with no output and no write. in_valid&frame_sync is processed as channel 0 and moves to FILL.
  - FILL: processes samples. On the write to channel NCH-1, moves to RUN and drops first_frame on the next cycle.
  - RUN: steady state.
- Processing a sample (FILL/RUN, in_valid=1), with slot k = 0 if frame_sync else wr_ch:
  - Y <= mem[k] (read-before-write, old contents).
  - mem[k] <= X; ch_out <= k; out_valid <= 1.
  - wr_ch <= k+1, wrapping from NCH-1 to 0.
- Latency and gaps:
  - Registered output, 1 cycle after the accepted sample.
  - Y for channel k equals the X accepted for channel k in the previous frame.
  - With in_valid held high, Y(t) = X(t-NCH-1).
- Idle cycle (in_valid=0): out_valid <= 0; Y, ch_out, wr_ch and memory hold. Gaps within a frame are legal.
- frame_sync with in_valid while wr_ch != 0 (FILL/RUN):
  - sync_err pulses 1 cycle; sample is written to channel 0; wr_ch <= 1.
  - first_frame re-asserts and state returns to FILL.
  - Stored entries are not cleared.
- frame_sync with in_valid=0: ignored.
- frame_sync with wr_ch=0: normal, no error.
- Width rules: no arithmetic on data. wr_ch compares against NCH-1, so NCH need not be a power of 2.

Optional Feature:
- Macro: CHAN_DELAY_PARITY_EN
- Defined:
  - Each entry stores SIZE+1 bits: data plus even parity computed on write.
  - On read, parity is recomputed. Output port par_err (1 bit) is registered alongside Y and is 1 when stored parity mismatches.
  - par_err resets to 0. Entries in FILL with first_frame=1 are never flagged (reset parity is consistent).
- Not defined: no par_err port, SIZE-bit storage, identical behaviour otherwise.

Decomposition:
- Package chan_delay_pkg: NCH/CW defaults, state encoding (SYNC_WAIT, FILL, RUN), parity helper function.
- One sub-module chan_slot_ctr:
  - Holds wr_ch.
  - Handles wrap at NCH-1, forced-zero on frame_sync, and misalignment detection.
  - Outputs slot index k, last_slot and misalign.

Test Plan:
- Reset then 3 frames continuous, X = frame*100 + ch:
  - Frame 0: Y=0 with first_frame=1.
  - Frame 1: Y = 0*100+ch, first_frame=0, ch_out tracks ch, each 1 cycle late.
- in_valid before any frame_sync (5 samples), then sync: no out_valid during the 5; first output ch_out=0.
- Random in_valid gaps over 4 frames: Y/ch_out hold during gaps; per-channel values still match the previous frame's values exactly.
- frame_sync at wr_ch=17 in RUN:
  - sync_err 1-cycle pulse; ch_out=0.
  - Next samples map to ch 1, 2, ...; first_frame=1 until channel 31 is written.
- Assert reset mid-frame (ch 12) for 1 cycle:
  - All outputs go to reset values immediately (asynchronous).
  - Next frame returns Y=RSTVAL.
- With CHAN_DELAY_PARITY_EN: force-flip bit 3 of the stored entry for ch 5; next frame ch 5 gives par_err=1; all other channels give par_err=0.
